// File: rtl/seq_det_param.sv
// Serial sequence detector with a runtime-programmable pattern of up to PAT_W bits.
// Supports overlapping and non-overlapping detection, a saturating match counter and prefix-depth status.
module seq_det_param #(
  parameter int               PAT_W   = 8,
  parameter int               LEN_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0010_1011),
  parameter int               DEF_LEN = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             ovl_i,
  input  logic             clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] state
);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] new_hist_s;
  logic [PAT_W-1:0] mask_s;
  logic [LEN_W:0]   fill_inc_s;
  logic             hit_s;
  logic             match_s;

  // Match evaluation: compares only the low len_q bits, and only once enough fresh bits exist.
  always_comb begin
    new_hist_s = {hist_q[PAT_W-2:0], in};
    fill_inc_s = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    mask_s     = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (i < int'(len_q));
    end
    hit_s = (len_q != '0) && (fill_inc_s >= {1'b0, len_q}) &&
            ((new_hist_s & mask_s) == (pat_q & mask_s));
  end

  // Next-state logic; priority is cfg_load over en, clr acts on the counter independently.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    out_d   = 1'b0;
    match_s = 1'b0;
    if (cfg_load) begin
      pat_d  = pat_i;
      len_d  = (len_i > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_i;
      ovl_d  = ovl_i;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d  = new_hist_s;
      match_s = hit_s;
      out_d   = hit_s;
      if (hit_s && !ovl_q) begin
        fill_d = '0;
      end else if (fill_inc_s >= {1'b0, len_q}) begin
        fill_d = len_q;
      end else begin
        fill_d = fill_inc_s[LEN_W-1:0];
      end
    end else begin
      hist_d = hist_q;
    end

    if (clr) begin
      cnt_d = '0;
    end else if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous reset to the default configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= DEF_PAT;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign state     = fill_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed scenarios then random traffic against a queue-based model.
// A second instance with a 2-bit counter shares all inputs to exercise counter saturation.
module tb_seq_det_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in;
  logic       cfg_load;
  logic [7:0] pat_i;
  logic [3:0] len_i;
  logic       ovl_i;
  logic       clr;
  logic       out_a, out_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [3:0] state_a, state_b;

  int checks = 0;
  int errors = 0;

  // Reference model: bits received since the last restart point, plus the latched config.
  bit         q[$];
  logic [7:0] pat_m;
  int         len_m;
  bit         ovl_m;
  bit         exp_out;
  int         exp_cnt8;
  int         exp_cnt2;

  seq_det_param dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .cfg_load(cfg_load),
    .pat_i(pat_i), .len_i(len_i), .ovl_i(ovl_i), .clr(clr),
    .out(out_a), .match_cnt(cnt_a), .state(state_a)
  );

  seq_det_param #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .cfg_load(cfg_load),
    .pat_i(pat_i), .len_i(len_i), .ovl_i(ovl_i), .clr(clr),
    .out(out_b), .match_cnt(cnt_b), .state(state_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int st;
    st = (q.size() < len_m) ? q.size() : len_m;
    check({tag, ".out_a"},   32'(out_a),   32'(exp_out));
    check({tag, ".out_b"},   32'(out_b),   32'(exp_out));
    check({tag, ".cnt_a"},   32'(cnt_a),   32'(exp_cnt8));
    check({tag, ".cnt_b"},   32'(cnt_b),   32'(exp_cnt2));
    check({tag, ".state_a"}, 32'(state_a), 32'(st));
    check({tag, ".state_b"}, 32'(state_b), 32'(st));
  endtask

  task automatic model_reset();
    q.delete();
    pat_m    = 8'b0010_1011;
    len_m    = 6;
    ovl_m    = 1'b1;
    exp_out  = 1'b0;
    exp_cnt8 = 0;
    exp_cnt2 = 0;
  endtask

  // Apply one clock edge with the given inputs and advance the model by one edge.
  task automatic step(input bit e, input bit b, input bit ld, input logic [7:0] p,
                      input logic [3:0] l, input bit o, input bit c, input string tag);
    bit hit;
    en = e; in = b; cfg_load = ld; pat_i = p; len_i = l; ovl_i = o; clr = c;
    @(posedge clk);
    hit = 1'b0;
    if (ld) begin
      pat_m = p;
      len_m = (int'(l) > 8) ? 8 : int'(l);
      ovl_m = o;
      q.delete();
    end else if (e) begin
      q.push_back(b);
      if (q.size() > 8) void'(q.pop_front());
      if (len_m != 0 && q.size() >= len_m) begin
        hit = 1'b1;
        for (int k = 0; k < len_m; k++) begin
          if (q[q.size() - 1 - k] != pat_m[k]) hit = 1'b0;
        end
      end
      if (hit && !ovl_m) q.delete();
    end
    exp_out = hit;
    if (c) begin
      exp_cnt8 = 0;
      exp_cnt2 = 0;
    end else if (hit) begin
      if (exp_cnt8 < 255) exp_cnt8++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    #1;
    check_all(tag);
  endtask

  task automatic feed(input logic [7:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, tag);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0, "cfg");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    en = 1'b0; in = 1'b0; cfg_load = 1'b0; pat_i = 8'h00; len_i = 4'd0; ovl_i = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_reset();

    feed(8'b0010_1011, 6, "default");
    check("default.cnt", 32'(cnt_a), 32'd1);

    load(8'b0000_1010, 4'd4, 1'b1);
    feed(8'b0101_0101, 7, "ovl");
    check("ovl.cnt", 32'(cnt_a), 32'd3);

    load(8'b0000_1010, 4'd4, 1'b0);
    feed(8'b0101_0101, 7, "novl");
    check("novl.state", 32'(state_a), 32'd3);

    load(8'b0000_0001, 4'd1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, "len1");
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, "len1.off");
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, "len1");
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, "len1.off");
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, "len1");

    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "clr");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, "sat");
    check("sat.cnt_b", 32'(cnt_b), 32'd3);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, "clr_hit");
    check("clr_hit.out", 32'(out_a), 32'd1);

    load(8'b0000_1010, 4'd4, 1'b1);
    feed(8'b0000_0101, 3, "mid");
    step(1'b1, 1'b0, 1'b1, 8'b0000_1010, 4'd4, 1'b1, 1'b0, "mid.cfg");
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, "mid.done");
    check("mid.out", 32'(out_a), 32'd0);

    feed(8'b0000_0101, 3, "rst");
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, "rst.done");
    feed(8'b0000_0000, 7, "rst.len");
    check("rst.len6", 32'(state_a), 32'd6);

    load(8'hA5, 4'd15, 1'b1);
    feed(8'hA5, 8, "clamp");
    check("clamp.out", 32'(out_a), 32'd1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0)
        step(1'($urandom), 1'($urandom), 1'b1, 8'($urandom), 4'($urandom), 1'($urandom),
             ($urandom_range(0, 15) == 0), "rnd.cfg");
      else
        step(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 8'($urandom), 4'($urandom),
             1'($urandom), ($urandom_range(0, 31) == 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial sequence detector. It compares a 1-bit input stream against a runtime-programmable pattern of up to PAT_W bits and pulses a match flag on each detection. Overlapping and non-overlapping detection are selectable, matches are counted, and the matched-prefix progress is exposed as a status output. It sits between the serial input sampler and the control/status logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of pat_len / state; must satisfy 2^LEN_W > PAT_W
CNT_W, 8, width of the match counter
DEF_PAT, 8'b0010_1011, pattern loaded at reset (LSBs used)
DEF_LEN, 6, pattern length loaded at reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  bit-valid strobe; in is sampled only when en=1
in  in  1  serial data bit
cfg_load  in  1  one-cycle strobe; latches pat_i, len_i, ovl_i
pat_i  in  PAT_W  pattern; pat_i[len-1] is the first bit received, pat_i[0] the last
len_i  in  LEN_W  pattern length
ovl_i  in  1  1 = overlapping detection, 0 = non-overlapping
clr  in  1  synchronous clear of match_cnt
out  out  1  registered match pulse
match_cnt  out  CNT_W  saturating match count
state  out  LEN_W  valid history depth, saturates at the latched length

Behaviour:
- Reset: all internal registers load asynchronously on rst_n low.
  - pat_r=DEF_PAT, len_r=DEF_LEN, ovl_r=1.
  - hist=0, fill=0.
  - out=0, match_cnt=0, state=0.
- Config latch: len_i values above PAT_W are clamped to PAT_W on load.
  - If len_r=0, the block never matches. fill stays 0.
- cfg_load=1 on a clock edge:
  - latch the config, clear hist and fill, and force out=0.
  - Any en/in in the same cycle is discarded (cfg_load has priority).
  - match_cnt is not affected.
- en=1, cfg_load=0 on a clock edge:
  - hist <= {hist[PAT_W-2:0], in}.
  - fill <= min(fill+1, len_r).
  - A match is declared when both hold: (fill+1) >= len_r, and the low len_r bits of the new hist equal pat_r[len_r-1:0].
- On a match:
  - out=1 for exactly one cycle following that edge (latency 1 edge from the completing bit).
  - match_cnt increments, saturating at 2^CNT_W-1.
  - Overlap mode: hist and fill keep shifting normally, so a suffix of the match can start the next one.
  - Non-overlap mode: fill <= 0. The next match requires len_r fresh bits.
- en=0: hist, fill and match_cnt hold. out <= 0.
- clr=1: match_cnt <= 0.
  - clr wins over a simultaneous increment. out still pulses for that match.
- state = fill (0..len_r). It is combinationally driven from the register.
- Boundary cases:
  - len_r=1: a match is possible on every enabled bit.
  - Back-to-back matches produce out high on consecutive cycles.
  - A reset in mid-stream discards partial matches and restores the DEF_* config.
- Unspecified conditions do not exist: every input combination has the priority order rst_n > cfg_load > en. clr is independent of en.

Test Plan:
- Reset defaults (101011, overlap), en=1, stream 1,0,1,0,1,1 -> out=1 the cycle after bit 6 only; match_cnt=1; state steps 1..6.
- cfg_load pat=4'b1010, len=4, ovl=1; stream 1,0,1,0,1,0,1 -> out pulses after bits 4 and 6; match_cnt=2.
- Same config with ovl=0, same stream -> out pulses after bit 4 only; match_cnt=1; state=3 after bit 7.
- len=1, pat=1, stream 1,1,1 with en toggled 1,0,1,0,1 -> three single-cycle pulses, each on an en cycle only; out=0 during en=0.
- CNT_W=2: 5 matches -> match_cnt saturates at 3; clr coincident with the 6th match -> match_cnt=0, out=1.
- Mid-pattern cfg_load, or rst_n low after 3 of 4 bits -> no match on the completing bit; state=0; reset case restores len=6.
